pipe_step_ctrl: RTL and testbench

- Sequences the 5-stage pipelined CPU by generating a single-cycle clock-enable (cpu_ce) that every pipeline stage uses in place of a raw button-derived clock.
- Supports three modes: single-step from a button, run-N-cycles, and free-run at a divided rate.
- Maintains the 8-bit cycle counter shown on the LCD.
- Sits between the debounced buttons/switches and the if/id/ex/mem/wb stages.

---
 rtl/pipe_step_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pipe_step_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_step_ctrl.sv
// pipe_step_ctrl: generates the pipeline advance strobe for the 5-stage CPU.
//
// Every IF/ID/EX/MEM/WB stage gates its registers with cpu_ce rather than
// being clocked from a button. This block produces that strobe in three
// modes:
//   - single step : one pulse per rising edge of step_btn
//   - counted run : run_count pulses, one every TICK_DIV clks
//   - free run    : one pulse every TICK_DIV clks until stop_btn
// It also keeps the LCD cycle counter.
//
// Optional feature macro: PIPE_STEP_CTRL_BKPT_EN
//   When defined, a RUN-mode tick with pc == bkpt_addr is swallowed and the
//   block parks in HALT. The first tick after leaving HALT does not compare,
//   so resuming steps past the breakpoint. Without the macro, HALT is
//   unreachable and pc/bkpt_addr are unused.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   step_btn   debounced step button (level)
//   run_btn    debounced run button (level)
//   stop_btn   debounced stop button (level)
//   free_run   1 = run until stopped, 0 = counted run (sampled at run start)
//   run_count  pulses for a counted run (sampled at run start)
//   pc         current IF-stage next PC
//   bkpt_addr  breakpoint PC
//   cpu_ce     one-clk pipeline advance pulse (registered)
//   cycle_cnt  pulses issued since reset, wraps
//   state      0 = IDLE, 1 = RUN, 2 = HALT
//   busy       high while state is RUN
module pipe_step_ctrl #(
  parameter int TICK_DIV = 25000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_btn,
  input  logic             run_btn,
  input  logic             stop_btn,
  input  logic             free_run,
  input  logic [CNT_W-1:0] run_count,
  input  logic [31:0]      pc,
  input  logic [31:0]      bkpt_addr,
  output logic             cpu_ce,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state,
  output logic             busy
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t st, st_nxt;

  logic             step_q, run_q, stop_q;
  logic             step_e, run_e, stop_e;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] remaining;
  logic             free_mode;

  logic tick;       // divider terminal clk while running
  logic last_tick;  // tick that delivers the final pulse of a counted run
  logic run_ok;     // run edge that actually starts something
  logic bkpt_hit;
  logic ce_nxt;
  logic start_run;

  // Rising edges only; a button held across reset never produces one
  // because the history registers load the live level during reset.
  assign step_e = step_btn & ~step_q;
  assign run_e  = run_btn  & ~run_q;
  assign stop_e = stop_btn & ~stop_q;

  assign tick      = (st == S_RUN) && (div == DIV_LAST);
  assign last_tick = tick && !free_mode && (remaining == CNT_W'(1));
  // A counted run of zero is a no-op.
  assign run_ok    = run_e && (free_run || (run_count != '0));

`ifdef PIPE_STEP_CTRL_BKPT_EN
  logic skip;  // one-shot: first tick after HALT ignores the breakpoint

  assign bkpt_hit = tick && !skip && (pc == bkpt_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      skip <= 1'b0;
    end else if (st == S_HALT && st_nxt != S_HALT) begin
      skip <= 1'b1;
    end else if (tick) begin
      skip <= 1'b0;
    end
  end
`else
  logic unused_bkpt;
  assign unused_bkpt = ^{pc, bkpt_addr};
  assign bkpt_hit    = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nxt;
  end

  // ---------------------------------------------------------------------
  // FSM: next state. Edge priority is stop > run > step.
  // ---------------------------------------------------------------------
  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE: begin
        if (!stop_e && run_ok) st_nxt = S_RUN;
      end
      S_RUN: begin
        if (stop_e)         st_nxt = S_IDLE;
        else if (bkpt_hit)  st_nxt = S_HALT;
        else if (last_tick) st_nxt = S_IDLE;
      end
      S_HALT: begin
        if (stop_e) begin
          st_nxt = S_IDLE;
        end else if (run_e) begin
          if (run_ok) st_nxt = S_RUN;
        end else if (step_e) begin
          st_nxt = S_IDLE;
        end
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs / datapath controls
  // ---------------------------------------------------------------------
  always_comb begin
    ce_nxt    = 1'b0;
    start_run = 1'b0;
    case (st)
      S_IDLE, S_HALT: begin
        if (!stop_e) begin
          if (run_e)       start_run = run_ok;
          else if (step_e) ce_nxt    = 1'b1;
        end
      end
      S_RUN: begin
        // stop on a terminal clk wins: no pulse goes out
        if (!stop_e && tick && !bkpt_hit) ce_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q    <= step_btn;
      run_q     <= run_btn;
      stop_q    <= stop_btn;
      div       <= '0;
      remaining <= '0;
      free_mode <= 1'b0;
      cpu_ce    <= 1'b0;
      busy      <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      step_q <= step_btn;
      run_q  <= run_btn;
      stop_q <= stop_btn;

      cpu_ce <= ce_nxt;
      busy   <= (st_nxt == S_RUN);
      if (ce_nxt) cycle_cnt <= cycle_cnt + CNT_W'(1);

      if (start_run) begin
        // entry clears the divider, so the first pulse is TICK_DIV clks out
        div       <= '0;
        remaining <= run_count;
        free_mode <= free_run;
      end else if (st == S_RUN) begin
        div <= tick ? '0 : div + DIV_W'(1);
        // a suppressed (breakpoint) tick leaves remaining untouched
        if (ce_nxt && !free_mode) remaining <= remaining - CNT_W'(1);
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Scoreboard bench for pipe_step_ctrl (TICK_DIV=4, CNT_W=8).
// Stimulus pushes the clk index and cycle_cnt value of each pulse it expects;
// a monitor pops one entry per observed cpu_ce pulse and compares.
module tb_pipe_step_ctrl;
  localparam int TD = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, step_btn, run_btn, stop_btn, free_run;
  logic [CW-1:0] run_count;
  logic [31:0]   pc_r, bkpt_addr;
  logic          cpu_ce, busy;
  logic [CW-1:0] cycle_cnt;
  logic [1:0]    state;

  pipe_step_ctrl #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .step_btn(step_btn), .run_btn(run_btn),
    .stop_btn(stop_btn), .free_run(free_run), .run_count(run_count),
    .pc(pc_r), .bkpt_addr(bkpt_addr), .cpu_ce(cpu_ce),
    .cycle_cnt(cycle_cnt), .state(state), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // IF-stage stand-in: pc advances by 4 on every pipeline advance
  always @(posedge clk) begin
    if (rst)         pc_r <= 32'h0;
    else if (cpu_ce) pc_r <= pc_r + 32'd4;
  end

  typedef struct {int at; logic [CW-1:0] cnt;} exp_t;
  exp_t q[$];
  logic [CW-1:0] exp_cnt;
  int n_chk = 0, n_pass = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, req, cyc);
  endfunction

  function automatic void expect_pulse(int at);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.at  = at;
    e.cnt = exp_cnt;
    q.push_back(e);
  endfunction

  // monitor
  logic prev_ce = 1'b0;
  always @(negedge clk) begin
    if (cpu_ce === 1'b1) begin
      exp_t e;
      chk("ce_spacing", {31'd0, prev_ce}, 32'd0);
      chk("pulse_expected", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pulse_cyc", e.at, cyc);
        chk("pulse_cnt", {24'd0, cycle_cnt}, {24'd0, e.cnt});
      end
    end
    prev_ce <= cpu_ce;
  end

  task automatic step_n(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_n(2);
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  int c;

  initial begin
    rst = 1'b1; step_btn = 0; run_btn = 0; stop_btn = 0; free_run = 0;
    run_count = '0; bkpt_addr = 32'hC; exp_cnt = '0;
    do_reset();
    step_n(1);

    // reset state
    sample();
    chk("rst_ce", {31'd0, cpu_ce}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {24'd0, cycle_cnt}, 32'd0);
    step_n(1);

    // three single steps, 10 clks apart
    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b1;
      expect_pulse(cyc + 1);
      step_n(1);
      step_btn = 1'b0;
      step_n(9);
    end
    sample();
    chk("step_cnt", {24'd0, cycle_cnt}, 32'd3);
    chk("step_state", {30'd0, state}, 32'd0);
    step_n(1);

    // counted run of 5
    c = cyc;
    free_run = 1'b0; run_count = 8'd5; run_btn = 1'b1;
    for (int k = 1; k <= 5; k++) expect_pulse(c + 1 + TD * k);
    step_n(1);
    run_btn = 1'b0;
    sample();
    chk("run_state", {30'd0, state}, 32'd1);
    chk("run_busy", {31'd0, busy}, 32'd1);
    goto(c + 20);
    sample();
    chk("busy_before_last", {31'd0, busy}, 32'd1);
    goto(c + 21);
    sample();
    chk("busy_with_last", {31'd0, busy}, 32'd0);
    chk("state_with_last", {30'd0, state}, 32'd0);
    goto(c + 28);
    sample();
    chk("run_cnt", {24'd0, cycle_cnt}, 32'd8);
    step_n(1);

    // free run, stop lands on a terminal clk
    c = cyc;
    free_run = 1'b1; run_btn = 1'b1;
    expect_pulse(c + 5);
    expect_pulse(c + 9);
    step_n(1);
    run_btn = 1'b0;
    goto(c + 12);
    stop_btn = 1'b1;
    step_n(1);
    sample();
    chk("stop_ce", {31'd0, cpu_ce}, 32'd0);
    chk("stop_state", {30'd0, state}, 32'd0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    step_n(1);
    stop_btn = 1'b0;
    step_n(8);
    chk("stop_cnt", {24'd0, cycle_cnt}, 32'd10);

    // run_count=0 is a no-op, then run+step together: run wins
    free_run = 1'b0; run_count = 8'd0; run_btn = 1'b1;
    step_n(1);
    run_btn = 1'b0;
    sample();
    chk("rc0_state", {30'd0, state}, 32'd0);
    step_n(6);
    c = cyc;
    run_count = 8'd3; run_btn = 1'b1; step_btn = 1'b1;
    for (int k = 1; k <= 3; k++) expect_pulse(c + 1 + TD * k);
    step_n(1);
    run_btn = 1'b0; step_btn = 1'b0;
    sample();
    chk("runstep_state", {30'd0, state}, 32'd1);
    chk("runstep_ce", {31'd0, cpu_ce}, 32'd0);
    goto(c + 16);
    sample();
    chk("runstep_end", {30'd0, state}, 32'd0);
    chk("runstep_cnt", {24'd0, cycle_cnt}, 32'd13);
    step_n(1);

    // preset counter to 255 with a counted run of 242, then step to wrap
    c = cyc;
    run_count = 8'd242; run_btn = 1'b1;
    for (int k = 1; k <= 242; k++) expect_pulse(c + 1 + TD * k);
    step_n(1);
    run_btn = 1'b0;
    goto(c + 969);
    sample();
    chk("preset_cnt", {24'd0, cycle_cnt}, 32'd255);
    goto(c + 971);
    step_btn = 1'b1;
    expect_pulse(c + 972);
    step_n(1);
    step_btn = 1'b0;
    sample();
    chk("wrap_cnt", {24'd0, cycle_cnt}, 32'd0);
    step_n(4);

    // reset mid-run on a terminal clk, run button held through reset
    c = cyc;
    free_run = 1'b1; run_btn = 1'b1;
    expect_pulse(c + 5);
    goto(c + 8);
    rst = 1'b1;
    exp_cnt = '0;
    step_n(1);
    sample();
    chk("midrst_ce", {31'd0, cpu_ce}, 32'd0);
    chk("midrst_state", {30'd0, state}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_cnt", {24'd0, cycle_cnt}, 32'd0);
    step_n(1);
    rst = 1'b0;
    step_n(8);
    chk("held_run_state", {30'd0, state}, 32'd0);
    run_btn = 1'b0;
    step_n(2);

`ifdef PIPE_STEP_CTRL_BKPT_EN
    // breakpoint at 0xC during a free run, then resume past it
    do_reset();
    step_n(1);
    c = cyc;
    bkpt_addr = 32'hC; free_run = 1'b1; run_btn = 1'b1;
    expect_pulse(c + 5);
    expect_pulse(c + 9);
    expect_pulse(c + 13);
    step_n(1);
    run_btn = 1'b0;
    goto(c + 17);
    sample();
    chk("bkpt_state", {30'd0, state}, 32'd2);
    chk("bkpt_ce", {31'd0, cpu_ce}, 32'd0);
    chk("bkpt_pc", pc_r, 32'hC);
    goto(c + 20);
    run_btn = 1'b1;
    expect_pulse(c + 25);
    step_n(1);
    run_btn = 1'b0;
    goto(c + 25);
    sample();
    chk("resume_ce", {31'd0, cpu_ce}, 32'd1);
    chk("resume_pc", pc_r, 32'hC);
    goto(c + 28);
    stop_btn = 1'b1;
    step_n(1);
    stop_btn = 1'b0;
    sample();
    chk("resume_stop", {30'd0, state}, 32'd0);
    step_n(4);
`endif

    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
